core_inst_seq: RTL and testbench
================================

# core_inst_seq

On-chip instruction sequencer that drives the core's 34-bit `inst` bus for one kij pass: weight SRAM→L0, kernel load to PEs, activation SRAM→L0, execute, OFIFO→psum SRAM. It replaces bench-side instruction stimulus as the initiator of the core instruction protocol.

- It sits directly in front of `core`.
- `inst` feeds `core.inst` and `ofifo_valid` comes back from `core`.

## Interface

- `col`, 8: PE columns; the number of weight rows per kij.
- `row`, 8: PE rows. Informational only.
- `len_nij`, 64: activation and output rows per pass.
- `len_kij`, 9: number of kernel positions.
- `gap`, 10: idle cycles inserted after kernel load and after execute.
- `clk` input 1: the single clock.
- `reset` input 1: synchronous, active-high.
- `start` input 1: one-cycle pulse that begins a pass.
- `kij` input 4: kernel index, sampled when `start` is accepted.
- `ofifo_valid` input 1: OFIFO has a row available.
- `inst` output 34: registered instruction word.
- `busy` output 1: a pass is in progress.
- `done` output 1: one-cycle pulse at the end of a pass.
- `err` output 1: one-cycle pulse when a start is rejected.

## Operation

- `inst` fields:
  - [33] `acc`
  - [32] `CEN_pmem`
  - [31] `WEN_pmem`
  - [30:20] `A_pmem`
  - [19] `CEN_xmem`
  - [18] `WEN_xmem`
  - [17:7] `A_xmem`
  - [6] `ofifo_rd`
  - [5] `ififo_wr`
  - [4] `ififo_rd`
  - [3] `l0_rd`
  - [2] `l0_wr`
  - [1] `execute`
  - [0] `load`
- IDLE word is 34'h1_800C_0000: both SRAMs disabled with CEN=1 and WEN=1; every other field 0.
- Memory map:
  - Activations occupy xmem 0..len_nij-1.
  - Weights for a given kij occupy xmem 0x400 + kij·col … +col-1.
  - Psums are written to pmem at kij·len_nij + n.
- States and behaviour (t = the phase counter, starting at 0):
  - IDLE: drive the IDLE word.
    - `start` with `kij`<len_kij → W_L0.
    - `start` with `kij`≥len_kij → pulse `err`, stay in IDLE.
  - W_L0: lasts col+1 cycles.
    - Cycles t<col: CEN_xmem=0, WEN_xmem=1, A_xmem = weight base + t.
    - Cycles t≥1: `l0_wr`=1, covering the 1-cycle SRAM read latency.
  - K_LOAD: col cycles with `l0_rd`=1 and `load`=1.
  - GAP1: gap cycles of the IDLE word.
  - A_L0: lasts len_nij+1 cycles.
    - Cycles t<len_nij: xmem read with A_xmem = t.
    - Cycles t≥1: `l0_wr`=1.
  - EXEC: len_nij cycles with `l0_rd`=1 and `execute`=1.
  - GAP2: gap cycles of the IDLE word.
  - OF_RD: continues until len_nij rows have been written.
    - `ofifo_rd` = `ofifo_valid` in the same cycle.
    - The cycle after each read: CEN_pmem=0, WEN_pmem=0, A_pmem = kij·len_nij + n, then n increments.
    - → DONE.
  - DONE: 1 cycle with the IDLE word and `done`=1 → IDLE.
- Only one state is active at a time.
- `start` is ignored while `busy`.
- A_pmem arithmetic is 11-bit; kij·len_nij + n ≤ 575 fits without wrap.

## Timing

- Reset values: `inst` = IDLE word; `busy`=0, `done`=0, `err`=0.
- `reset` asserted in any state forces IDLE on the next edge. Any partial L0 or pmem activity is abandoned.
- `inst` is registered: a state's first word appears the cycle after entering that state.
- `busy` rises the cycle after `start` is accepted and falls together with the `done` pulse.
- Pass latency with defaults, when `ofifo_valid` is held high: 9+8+10+65+64+10+65+1 = 232 cycles from `start` to `done`.
- OF_RD stalls indefinitely while `ofifo_valid`=0. There is no timeout.
- If `ofifo_valid` drops mid-burst, the pmem write occurs only for cycles that actually read; addresses stay contiguous.

## Configuration

- `INST_SEQ_PERF_EN` defined:
  - Adds output `perf_cycles` [15:0], which counts busy cycles of the last pass.
  - The counter clears on accepted `start`, holds after `done`, and saturates at 16'hFFFF.
  - Reset value is 0.
- `INST_SEQ_PERF_EN` undefined: the port and counter do not exist. All other behaviour is identical.

## Structure

- Package `inst_seq_pkg` contains:
  - field bit-position constants;
  - the IDLE word constant;
  - the state enum;
  - the weight base address 0x400.
- One sub-module, `inst_seq_cnt`:
  - a loadable phase counter with terminal-count flag;
  - shared across W_L0, K_LOAD, GAP, A_L0 and EXEC.

## Test plan

- Reset held for 10 cycles, then released → `inst`=34'h1_800C_0000, `busy`=0, with no pulses on `done` or `err`.
- `start` with `kij`=3 and `ofifo_valid`=1 → A_xmem sequence 0x418..0x41F, then `l0_wr` for 8 cycles; `done` arrives 232 cycles after `start`; pmem writes cover addresses 192..255.
- `kij`=9 → `err` pulses once, `busy` stays 0, `inst` stays the IDLE word.
- `ofifo_valid` toggled 1/0 during OF_RD → exactly 64 pmem writes with contiguous addresses; `done` arrives only after the 64th write.
- `reset` asserted mid-EXEC → the next `inst` is the IDLE word and `busy`=0; a following `start` with `kij`=0 completes normally.
- With `INST_SEQ_PERF_EN` defined: default pass → `perf_cycles`=232 after `done`, held until the next `start`.

Source files
------------

// File: rtl/inst_seq_pkg.sv
// Shared definitions for the core instruction sequencer: inst field positions,
// the IDLE word, the sequencer state encoding and the weight base address.
package inst_seq_pkg;

  localparam int unsigned InstW = 34;
  localparam int unsigned AddrW = 11;
  localparam int unsigned CntW  = 16;

  localparam int unsigned BitAcc     = 33;
  localparam int unsigned BitCenP    = 32;
  localparam int unsigned BitWenP    = 31;
  localparam int unsigned APMsb      = 30;
  localparam int unsigned APLsb      = 20;
  localparam int unsigned BitCenX    = 19;
  localparam int unsigned BitWenX    = 18;
  localparam int unsigned AXMsb      = 17;
  localparam int unsigned AXLsb      = 7;
  localparam int unsigned BitOfifoRd = 6;
  localparam int unsigned BitIfifoWr = 5;
  localparam int unsigned BitIfifoRd = 4;
  localparam int unsigned BitL0Rd    = 3;
  localparam int unsigned BitL0Wr    = 2;
  localparam int unsigned BitExec    = 1;
  localparam int unsigned BitLoad    = 0;

  // Both SRAMs deselected (CEN=1, WEN=1), every strobe low.
  localparam logic [InstW-1:0] IdleWord   = 34'h1_800C_0000;
  localparam logic [AddrW-1:0] WeightBase = 11'h400;

  typedef enum logic [3:0] {
    StIdle,
    StWL0,
    StKLoad,
    StGap1,
    StAL0,
    StExec,
    StGap2,
    StOfRd,
    StDone
  } state_e;

endpackage

// File: rtl/inst_seq_cnt.sv
// Phase counter shared by the fixed-length sequencer phases: synchronously
// cleared on phase entry, flags the last cycle of the phase.
module inst_seq_cnt
  import inst_seq_pkg::*;
#(
  parameter int unsigned Width = CntW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [Width-1:0] last,
  output logic [Width-1:0] cnt,
  output logic             tc
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == last);

endmodule

// File: rtl/core_inst_seq.sv
// Instruction sequencer driving core.inst for one kij pass.
// Define INST_SEQ_PERF_EN to add the perf_cycles busy-cycle counter output.
module core_inst_seq
  import inst_seq_pkg::*;
#(
  parameter int unsigned col     = 8,
  parameter int unsigned row     = 8,
  parameter int unsigned len_nij = 64,
  parameter int unsigned len_kij = 9,
  parameter int unsigned gap     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       kij,
  input  logic             ofifo_valid,
  output logic [InstW-1:0] inst,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef INST_SEQ_PERF_EN
  ,
  output logic [15:0]      perf_cycles
`endif
);

  state_e           state_q, state_d;
  logic [3:0]       kij_q;
  logic [InstW-1:0] inst_q, inst_d;
  logic             busy_q, done_q, err_q;
  logic [CntW-1:0]  t, last;
  logic             tc, phase_clr;
  logic             kij_ok, start_ok, start_bad;
  logic [CntW-1:0]  rd_cnt_q, wr_cnt_q;
  logic             rd, wr;

  // Row count is informational only.
  logic unused_row;
  assign unused_row = ^32'(row);

  assign kij_ok    = (32'(kij) < len_kij);
  assign start_ok  = (state_q == StIdle) && start && kij_ok;
  assign start_bad = (state_q == StIdle) && start && !kij_ok;

  // A read issued last cycle (visible in inst_q) is written to pmem this cycle.
  assign rd = (state_q == StOfRd) && ofifo_valid && (rd_cnt_q < CntW'(len_nij));
  assign wr = (state_q == StOfRd) && inst_q[BitOfifoRd];

  assign phase_clr = (state_d != state_q);

  inst_seq_cnt #(
    .Width(CntW)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (phase_clr),
    .last (last),
    .cnt  (t),
    .tc   (tc)
  );

  always_comb begin
    last = '0;
    unique case (state_q)
      StWL0:          last = CntW'(col);
      StKLoad:        last = CntW'(col - 1);
      StGap1, StGap2: last = CntW'(gap - 1);
      StAL0:          last = CntW'(len_nij);
      StExec:         last = CntW'(len_nij - 1);
      default:        last = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StWL0;
      StWL0:   if (tc) state_d = StKLoad;
      StKLoad: if (tc) state_d = StGap1;
      StGap1:  if (tc) state_d = StAL0;
      StAL0:   if (tc) state_d = StExec;
      StExec:  if (tc) state_d = StGap2;
      StGap2:  if (tc) state_d = StOfRd;
      StOfRd:  if (wr && (wr_cnt_q == CntW'(len_nij - 1))) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    inst_d = IdleWord;
    unique case (state_q)
      StWL0: begin
        if (t < CntW'(col)) begin
          inst_d[BitCenX]     = 1'b0;
          inst_d[AXMsb:AXLsb] = WeightBase + AddrW'(32'(kij_q) * col) + AddrW'(t);
        end
        inst_d[BitL0Wr] = (t != '0);
      end
      StKLoad: begin
        inst_d[BitL0Rd] = 1'b1;
        inst_d[BitLoad] = 1'b1;
      end
      StAL0: begin
        if (t < CntW'(len_nij)) begin
          inst_d[BitCenX]     = 1'b0;
          inst_d[AXMsb:AXLsb] = AddrW'(t);
        end
        inst_d[BitL0Wr] = (t != '0);
      end
      StExec: begin
        inst_d[BitL0Rd] = 1'b1;
        inst_d[BitExec] = 1'b1;
      end
      StOfRd: begin
        inst_d[BitOfifoRd] = rd;
        if (wr) begin
          inst_d[BitCenP]     = 1'b0;
          inst_d[BitWenP]     = 1'b0;
          inst_d[APMsb:APLsb] = AddrW'(32'(kij_q) * len_nij) + AddrW'(wr_cnt_q);
        end
      end
      default: inst_d = IdleWord;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      kij_q    <= '0;
      inst_q   <= IdleWord;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) kij_q <= kij;
      inst_q <= inst_d;
      // busy drops on the same edge that raises done.
      busy_q <= (state_d != StIdle);
      done_q <= (state_q == StDone);
      err_q  <= start_bad;
      if (state_q != StOfRd) begin
        rd_cnt_q <= '0;
        wr_cnt_q <= '0;
      end else begin
        if (rd) rd_cnt_q <= rd_cnt_q + 1'b1;
        if (wr) wr_cnt_q <= wr_cnt_q + 1'b1;
      end
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

`ifdef INST_SEQ_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      perf_q <= '0;
    end else if (busy_q && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 1'b1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_core_inst_seq.sv
// Self-checking bench for core_inst_seq against a pass-level instruction model.
module tb_core_inst_seq;

  localparam logic [33:0] IDLE = 34'h1_800C_0000;
  localparam int COL = 8;
  localparam int NIJ = 64;
  localparam int GAP = 10;

  logic        clk = 1'b0;
  logic        reset, start, ofifo_valid, busy, done, err;
  logic [3:0]  kij;
  logic [33:0] inst;
`ifdef INST_SEQ_PERF_EN
  logic [15:0] perf_cycles;
`endif

  int errors = 0;
  int checks = 0;

  core_inst_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .kij        (kij),
    .ofifo_valid(ofifo_valid),
    .inst       (inst),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef INST_SEQ_PERF_EN
    ,
    .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Observations of the most recent pass.
  logic [33:0] words[$];
  int          xq[$];
  int          pq[$];
  int          lat, busy_gaps, busy_at_done, wr_orphan, rd_novalid, last_wr_k, n_ofrd, n_err;

  function automatic logic [33:0] xrd(input int a);
    logic [33:0] w;
    w        = IDLE;
    w[19]    = 1'b0;
    w[17:7]  = 11'(a);
    return w;
  endfunction

  function automatic logic [33:0] pwr(input int a);
    logic [33:0] w;
    w        = IDLE;
    w[32]    = 1'b0;
    w[31]    = 1'b0;
    w[30:20] = 11'(a);
    return w;
  endfunction

  // vmode: 0 valid held high, 1 toggling, 2 random. inject_k: stray start at that cycle.
  task automatic run_pass(input int kv, input int vmode, input int inject_k);
    logic prev_rd;
    words.delete(); xq.delete(); pq.delete();
    lat = -1; busy_gaps = 0; busy_at_done = -1; wr_orphan = 0; rd_novalid = 0;
    last_wr_k = -1; n_ofrd = 0; n_err = 0; prev_rd = 1'b0;
    kij = 4'(kv);
    start = 1'b1;
    ofifo_valid = 1'b1;
    for (int k = 1; k <= 4000; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == inject_k) begin
        start = 1'b1;
        kij   = 4'((kv + 1) % 9);
      end
      words.push_back(inst);
      if (!inst[19]) xq.push_back(int'(inst[17:7]));
      if (!inst[32] && !inst[31]) begin
        pq.push_back(int'(inst[30:20]));
        last_wr_k = k;
        if (!prev_rd) wr_orphan++;
      end
      if (inst[6]) begin
        n_ofrd++;
        if (!ofifo_valid) rd_novalid++;
      end
      if (err) n_err++;
      prev_rd = inst[6];
      if (done) begin
        lat = k - 1;
        busy_at_done = int'(busy);
        break;
      end
      if (!busy) busy_gaps++;
      case (vmode)
        0:       ofifo_valid = 1'b1;
        1:       ofifo_valid = (k % 2 == 0);
        default: ofifo_valid = 1'($urandom_range(0, 1));
      endcase
    end
    start = 1'b0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL pass_timeout: no done within budget (kij=%0d)", kv);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; kij = '0; ofifo_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (inst !== IDLE) begin errors++; $display("FAIL reset_inst: got %h want %h", inst, IDLE); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    end
`ifdef INST_SEQ_PERF_EN
    checks++; if (perf_cycles !== 16'd0) begin errors++; $display("FAIL reset_perf: got %0d want 0", perf_cycles); end
`endif
  endtask

  task automatic test_full_pass(input int kv);
    logic [33:0] exp_q[$];
    logic [33:0] w;
    exp_q.push_back(IDLE);
    for (int t = 0; t <= COL; t++) begin
      w = (t < COL) ? xrd(1024 + kv * COL + t) : IDLE;
      if (t >= 1) w[2] = 1'b1;
      exp_q.push_back(w);
    end
    repeat (COL) begin w = IDLE; w[3] = 1'b1; w[0] = 1'b1; exp_q.push_back(w); end
    repeat (GAP) exp_q.push_back(IDLE);
    for (int t = 0; t <= NIJ; t++) begin
      w = (t < NIJ) ? xrd(t) : IDLE;
      if (t >= 1) w[2] = 1'b1;
      exp_q.push_back(w);
    end
    repeat (NIJ) begin w = IDLE; w[3] = 1'b1; w[1] = 1'b1; exp_q.push_back(w); end
    repeat (GAP) exp_q.push_back(IDLE);
    for (int t = 0; t <= NIJ; t++) begin
      w = (t >= 1) ? pwr(kv * NIJ + t - 1) : IDLE;
      if (t < NIJ) w[6] = 1'b1;
      exp_q.push_back(w);
    end
    exp_q.push_back(IDLE);

    run_pass(kv, 0, 0);
    checks++; if (lat != 232) begin errors++; $display("FAIL full_latency: got %0d want 232", lat); end
    checks++; if (words.size() != exp_q.size()) begin
      errors++; $display("FAIL full_len: got %0d want %0d", words.size(), exp_q.size());
    end
    for (int i = 0; i < words.size() && i < exp_q.size(); i++) begin
      checks++;
      if (words[i] !== exp_q[i]) begin
        errors++; $display("FAIL full_word[%0d]: got %h want %h", i, words[i], exp_q[i]);
      end
    end
    checks++; if (xq.size() < 1 || xq[0] != 1024 + kv * COL) begin
      errors++; $display("FAIL full_first_waddr: got %0d entries want first %0d", xq.size(), 1024 + kv * COL);
    end
    checks++; if (pq.size() != NIJ || pq[0] != kv * NIJ || pq[NIJ-1] != kv * NIJ + NIJ - 1) begin
      errors++; $display("FAIL full_pmem_range: got %0d writes want %0d..%0d", pq.size(), kv * NIJ, kv * NIJ + NIJ - 1);
    end
    checks++; if (busy_gaps != 0) begin errors++; $display("FAIL full_busy: got %0d low cycles want 0", busy_gaps); end
    checks++; if (busy_at_done != 0) begin errors++; $display("FAIL full_busy_at_done: got %0d want 0", busy_at_done); end
    checks++; if (n_err != 0) begin errors++; $display("FAIL full_err: got %0d pulses want 0", n_err); end
`ifdef INST_SEQ_PERF_EN
    checks++; if (perf_cycles !== 16'd232) begin errors++; $display("FAIL perf_after_done: got %0d want 232", perf_cycles); end
    repeat (5) @(negedge clk);
    checks++; if (perf_cycles !== 16'd232) begin errors++; $display("FAIL perf_hold: got %0d want 232", perf_cycles); end
`endif
  endtask

  task automatic test_bad_kij(input int kv);
    kij = 4'(kv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_kij_err: got %b want 1 (kij=%0d)", err, kv); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_kij_busy: got %b want 0", busy); end
    checks++; if (inst !== IDLE) begin errors++; $display("FAIL bad_kij_inst: got %h want %h", inst, IDLE); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (err !== 1'b0 || busy !== 1'b0 || inst !== IDLE) begin
        errors++; $display("FAIL bad_kij_after: got err=%b busy=%b inst=%h want 0 0 %h", err, busy, inst, IDLE);
      end
    end
  endtask

  task automatic test_ofifo_stall(input int vmode);
    int kv;
    kv = int'($urandom_range(0, 8));
    run_pass(kv, vmode, 0);
    checks++; if (pq.size() != NIJ) begin errors++; $display("FAIL stall_nwr: got %0d want %0d", pq.size(), NIJ); end
    for (int i = 0; i < pq.size(); i++) begin
      checks++;
      if (pq[i] != kv * NIJ + i) begin
        errors++; $display("FAIL stall_addr[%0d]: got %0d want %0d", i, pq[i], kv * NIJ + i);
      end
    end
    checks++; if (n_ofrd != NIJ) begin errors++; $display("FAIL stall_nrd: got %0d want %0d", n_ofrd, NIJ); end
    checks++; if (wr_orphan != 0) begin errors++; $display("FAIL stall_wr_without_rd: got %0d want 0", wr_orphan); end
    checks++; if (rd_novalid != 0) begin errors++; $display("FAIL stall_rd_without_valid: got %0d want 0", rd_novalid); end
    checks++; if (lat < 0 || last_wr_k != lat) begin
      errors++; $display("FAIL stall_done_after_last_wr: got last_wr=%0d want %0d", last_wr_k, lat);
    end
    checks++; if (xq.size() != COL + NIJ) begin errors++; $display("FAIL stall_nxrd: got %0d want %0d", xq.size(), COL + NIJ); end
    checks++; if (busy_gaps != 0) begin errors++; $display("FAIL stall_busy: got %0d low cycles want 0", busy_gaps); end
`ifdef INST_SEQ_PERF_EN
    checks++; if (int'(perf_cycles) != lat) begin errors++; $display("FAIL stall_perf: got %0d want %0d", perf_cycles, lat); end
`endif
  endtask

  task automatic test_reset_mid_exec();
    kij = 4'd5;
    start = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++; if (inst[1] !== 1'b1) begin errors++; $display("FAIL mid_exec_setup: got execute=%b want 1", inst[1]); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (inst !== IDLE) begin errors++; $display("FAIL mid_reset_inst: got %h want %h", inst, IDLE); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    run_pass(0, 0, 0);
    checks++; if (lat != 232) begin errors++; $display("FAIL after_reset_latency: got %0d want 232", lat); end
    checks++; if (pq.size() != NIJ || pq[0] != 0 || pq[NIJ-1] != NIJ - 1) begin
      errors++; $display("FAIL after_reset_pmem: got %0d writes want 0..%0d", pq.size(), NIJ - 1);
    end
  endtask

  task automatic test_back_to_back();
    run_pass(8, 0, 50);
    checks++; if (lat != 232) begin errors++; $display("FAIL b2b_latency: got %0d want 232", lat); end
    checks++; if (xq.size() < 1 || xq[0] != 1024 + 8 * COL) begin
      errors++; $display("FAIL b2b_waddr: got %0d entries want first %0d", xq.size(), 1024 + 8 * COL);
    end
    checks++; if (pq.size() != NIJ || pq[0] != 512 || pq[NIJ-1] != 575) begin
      errors++; $display("FAIL b2b_pmem: got %0d writes want 512..575", pq.size());
    end
    run_pass(1, 2, 0);
    checks++; if (lat < 232) begin errors++; $display("FAIL b2b2_latency: got %0d want >=232", lat); end
    checks++; if (pq.size() != NIJ || pq[0] != 64 || pq[NIJ-1] != 127) begin
      errors++; $display("FAIL b2b2_pmem: got %0d writes want 64..127", pq.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_pass(3);
    test_bad_kij(9);
    test_bad_kij(15);
    test_ofifo_stall(1);
    test_ofifo_stall(2);
    test_reset_mid_exec();
    test_back_to_back();
    test_full_pass(int'($urandom_range(0, 8)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
